// File: rtl/aib_link_seq_pkg.sv
// Shared types for the AIB channel bring-up sequencer: state encoding,
// registered output bundle and the per-state output decode.
package aib_link_seq_pkg;

  localparam int unsigned TMR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DETECT = 3'd1,
    ST_RESET  = 3'd2,
    ST_CONFIG = 3'd3,
    ST_LOCK   = 3'd4,
    ST_UP     = 3'd5,
    ST_FAULT  = 3'd6
  } link_state_e;

  typedef struct packed {
    logic       adapter_rstn;
    logic       mac_rdy;
    logic       config_done;
    logic       tx_lock_req;
    logic       rx_lock_req;
    logic       itxen;
    logic [2:0] irxen;
    logic       link_up;
    logic       link_fault;
  } link_out_t;

  // Each bring-up stage keeps the outputs of the stages before it asserted.
  function automatic link_out_t decode_outputs(link_state_e s, logic [2:0] rxen_on);
    link_out_t o;
    o              = '0;
    o.adapter_rstn = (s == ST_CONFIG) || (s == ST_LOCK) || (s == ST_UP);
    o.config_done  = (s == ST_CONFIG) || (s == ST_LOCK) || (s == ST_UP);
    o.mac_rdy      = (s == ST_LOCK) || (s == ST_UP);
    o.tx_lock_req  = (s == ST_LOCK) || (s == ST_UP);
    o.rx_lock_req  = (s == ST_LOCK) || (s == ST_UP);
    o.itxen        = (s == ST_UP);
    o.irxen        = (s == ST_UP) ? rxen_on : 3'b000;
    o.link_up      = (s == ST_UP);
    o.link_fault   = (s == ST_FAULT);
    return o;
  endfunction

endpackage

// File: rtl/aib_seq_timer.sv
// Loadable saturating up-counter with clear/enable and a terminal-hit flag
// that reports the increment landing on term_i.
module aib_seq_timer
  import aib_link_seq_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_inc;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + W'(1);

  // Independent of clr_i so the owner can feed it into its next-state logic
  // and derive clr_i from that next state without a combinational loop.
  assign hit_o = en_i && (cnt_inc == term_i);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aib_link_seq.sv
// AIB channel bring-up sequencer: detect, adapter reset, config, lock, up,
// with link supervision and a per-state timeout into a sticky fault.
module aib_link_seq
  import aib_link_seq_pkg::*;
#(
  parameter int unsigned      DET_CYC = 8,
  parameter int unsigned      RST_CYC = 32,
  parameter logic [TMR_W-1:0] TMO_CYC = 16'd50000,
  parameter logic [2:0]       RXEN_ON = 3'b001
) (
  input  logic       osc_clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic       ms_nsl,
  input  logic       por_i,
  input  logic       device_detect_i,
  input  logic       fs_mac_rdy_i,
  input  logic       ms_tx_transfer_en,
  input  logic       ms_rx_transfer_en,
  input  logic       sl_tx_transfer_en,
  input  logic       sl_rx_transfer_en,
  output logic       ns_adapter_rstn,
  output logic       ns_mac_rdy,
  output logic       config_done,
  output logic       tx_dcc_dll_lock_req,
  output logic       rx_dcc_dll_lock_req,
  output logic       itxen,
  output logic [2:0] irxen,
  output logic       link_up,
  output logic       link_fault,
  output logic [2:0] state
);

  localparam logic [TMR_W-1:0] DET_TERM = TMR_W'(DET_CYC);
  localparam logic [TMR_W-1:0] RST_TERM = TMR_W'(RST_CYC);

  link_state_e      state_q, state_d;
  logic             role_q, role_d;
  link_out_t        out_q, out_d;

  logic             tx_sel, rx_sel, state_chg;
  logic             seq_en, seq_clr, seq_hit;
  logic [TMR_W-1:0] seq_term;
  logic             tmo_en, tmo_hit_raw, tmo_hit;

  assign tx_sel    = role_q ? ms_tx_transfer_en : sl_tx_transfer_en;
  assign rx_sel    = role_q ? ms_rx_transfer_en : sl_rx_transfer_en;
  assign state_chg = (state_d != state_q);

  // One counter serves both the detect debounce and the adapter reset hold.
  assign seq_term = (state_q == ST_DETECT) ? DET_TERM : RST_TERM;
  assign seq_en   = ((state_q == ST_DETECT) && device_detect_i) || (state_q == ST_RESET);
  assign seq_clr  = state_chg || ((state_q == ST_DETECT) && !device_detect_i);

  assign tmo_en  = (state_q == ST_DETECT) || (state_q == ST_CONFIG) || (state_q == ST_LOCK);
  assign tmo_hit = (TMO_CYC != '0) && tmo_hit_raw;

  aib_seq_timer #(.W(TMR_W)) u_seq_tmr (
    .clk        (osc_clk),
    .rst        (rst),
    .clr_i      (seq_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (seq_en),
    .term_i     (seq_term),
    .hit_o      (seq_hit)
  );

  aib_seq_timer #(.W(TMR_W)) u_tmo_tmr (
    .clk        (osc_clk),
    .rst        (rst),
    .clr_i      (state_chg),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (tmo_en),
    .term_i     (TMO_CYC),
    .hit_o      (tmo_hit_raw)
  );

  always_comb begin
    state_d = state_q;
    role_d  = role_q;
    if (por_i || !link_en) begin
      state_d = ST_IDLE;
    end else begin
      // Advance conditions are tested before the timeout so they win a tie.
      unique case (state_q)
        ST_IDLE:   state_d = ST_DETECT;
        ST_DETECT: if (seq_hit) state_d = ST_RESET;
                   else if (tmo_hit) state_d = ST_FAULT;
        ST_RESET:  if (seq_hit) state_d = ST_CONFIG;
        ST_CONFIG: if (fs_mac_rdy_i) state_d = ST_LOCK;
                   else if (tmo_hit) state_d = ST_FAULT;
        ST_LOCK:   if (tx_sel && rx_sel) state_d = ST_UP;
                   else if (tmo_hit) state_d = ST_FAULT;
        ST_UP:     if (!device_detect_i || !fs_mac_rdy_i || !tx_sel || !rx_sel)
                     state_d = ST_FAULT;
        ST_FAULT:  state_d = ST_FAULT;
        default:   state_d = ST_IDLE;
      endcase
    end
    if ((state_q == ST_IDLE) && (state_d == ST_DETECT)) begin
      role_d = ms_nsl;
    end
    out_d = decode_outputs(state_d, RXEN_ON);
  end

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      role_q  <= 1'b0;
      out_q   <= decode_outputs(ST_IDLE, RXEN_ON);
    end else begin
      state_q <= state_d;
      role_q  <= role_d;
      out_q   <= out_d;
    end
  end

  assign ns_adapter_rstn     = out_q.adapter_rstn;
  assign ns_mac_rdy          = out_q.mac_rdy;
  assign config_done         = out_q.config_done;
  assign tx_dcc_dll_lock_req = out_q.tx_lock_req;
  assign rx_dcc_dll_lock_req = out_q.rx_lock_req;
  assign itxen               = out_q.itxen;
  assign irxen               = out_q.irxen;
  assign link_up             = out_q.link_up;
  assign link_fault          = out_q.link_fault;
  assign state               = state_q;

endmodule
